aes_ct_serializer: RTL and testbench

Downstream consumer of the AES encrypter's output FIFO. It tracks how many ciphertext blocks the FIFO holds by counting `valid_out` pulses, pops one block at a time through `fifo_rd_en_t`, and emits each 128-bit block as a sequence of `WORD_W`-bit words on a valid/ready stream toward the host bus. It also keeps a block counter and a sticky overflow flag for status.

---
 rtl/aes_ct_serializer.sv | 107 ++++++++++
 tb/tb_aes_ct_serializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ct_serializer.sv
// Pops ciphertext blocks from the encrypter's output FIFO and streams each one
// out as WORD_W-bit words, most significant word first, on a valid/ready port.
module aes_ct_serializer #(
   parameter  int WORD_W = 32,
   parameter  int DEPTH  = 16,
   localparam int NWORDS = 128 / WORD_W,
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ct_valid,
   input  logic [127:0]      ct_data,
   output logic              fifo_rd_en_t,
   output logic [WORD_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic [CW-1:0]     credits,
   output logic [15:0]       blk_cnt,
   output logic              overflow
);

   localparam int            IW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);
   localparam logic [IW-1:0] PREV_IDX = IW'(NWORDS - 2);
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, POP, CAPT, SEND} state_t;

   state_t        state;
   state_t        state_nx;
   logic [127:0]  shift_buf;
   logic [IW-1:0] idx;
   logic          pop;
   logic          hs;
   logic          last_hs;

   assign pop          = (state == POP);
   assign hs           = m_valid & m_ready;
   assign last_hs      = hs & (idx == LAST_IDX);
   assign fifo_rd_en_t = pop;
   assign m_data       = shift_buf[127 -: WORD_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (credits != '0) state_nx = POP;
         POP:     state_nx = CAPT;
         CAPT:    state_nx = SEND;
         SEND:    if (last_hs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // A push arriving while full is lost in the FIFO itself, so the count holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits  <= '0;
         overflow <= 1'b0;
      end else if (ct_valid && !pop) begin
         if (credits == FULL) overflow <= 1'b1;
         else                 credits  <= credits + 1'b1;
      end else if (pop && !ct_valid) begin
         credits <= credits - 1'b1;
      end
   end

   // m_valid and m_last are registered so m_ready never reaches an output combinationally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_buf <= '0;
         idx       <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         blk_cnt   <= '0;
      end else begin
         case (state)
            CAPT: begin
               shift_buf <= ct_data;
               idx       <= '0;
               m_valid   <= 1'b1;
               m_last    <= (NWORDS == 1);
            end
            SEND: begin
               if (hs) begin
                  if (idx == LAST_IDX) begin
                     m_valid <= 1'b0;
                     m_last  <= 1'b0;
                     blk_cnt <= blk_cnt + 16'd1;
                  end else begin
                     shift_buf <= shift_buf << WORD_W;
                     idx       <= idx + 1'b1;
                     m_last    <= (idx == PREV_IDX);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Bench for aes_ct_serializer: a FIFO model feeds ct_data, a queue scoreboard
// checks every accepted word, and directed sequences check timing and status.
module tb_aes_ct_serializer;

   localparam int WORD_W = 32;
   localparam int DEPTH  = 16;
   localparam int NWORDS = 128 / WORD_W;
   localparam int CW     = $clog2(DEPTH + 1);

   logic              clk;
   logic              rst;
   logic              ct_valid;
   logic [127:0]      ct_data;
   logic              fifo_rd_en_t;
   logic [WORD_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;
   logic [CW-1:0]     credits;
   logic [15:0]       blk_cnt;
   logic              overflow;

   int total;
   int bad;
   int pop_count;
   int word_count;

   logic [127:0]  fifo_q[$];
   logic [WORD_W:0] exp_q[$];
   logic [WORD_W:0] mon_exp;

   localparam logic [127:0] V1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

   aes_ct_serializer #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .ct_valid(ct_valid),
      .ct_data(ct_data),
      .fifo_rd_en_t(fifo_rd_en_t),
      .m_data(m_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_last(m_last),
      .credits(credits),
      .blk_cnt(blk_cnt),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Writes one block into the FIFO model; a full FIFO drops it, as the real one does.
   task automatic apply_stimulus(input logic [127:0] blk);
      ct_valid = 1'b1;
      if (fifo_q.size() < DEPTH) begin
         fifo_q.push_back(blk);
         for (int w = 0; w < NWORDS; w++)
            exp_q.push_back({(w == NWORDS - 1), blk[127 - w*WORD_W -: WORD_W]});
      end
   endtask

   task automatic wait_blocks(input int target, input int budget);
      int n;
      n = 0;
      while (blk_cnt != 16'(target) && n < budget) begin
         tick();
         n++;
      end
      check_output("drain_blk_cnt", 128'(blk_cnt), 128'(target));
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_rd_en"},    128'(fifo_rd_en_t), 128'(0));
      check_output({tag, "_m_valid"},  128'(m_valid),      128'(0));
      check_output({tag, "_m_last"},   128'(m_last),       128'(0));
      check_output({tag, "_m_data"},   128'(m_data),       128'(0));
      check_output({tag, "_credits"},  128'(credits),      128'(0));
      check_output({tag, "_blk_cnt"},  128'(blk_cnt),      128'(0));
      check_output({tag, "_overflow"}, 128'(overflow),     128'(0));
   endtask

   // FIFO read data appears the cycle after the pop.
   always @(posedge clk) begin
      if (rst && fifo_rd_en_t) begin
         pop_count++;
         check_output("pop_nonempty", 128'(fifo_q.size() != 0), 128'(1));
         if (fifo_q.size() != 0) ct_data <= fifo_q.pop_front();
      end
   end

   always @(negedge clk) begin
      #1;
      if (rst && m_valid && m_ready) begin
         word_count++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_word: got 0x%0h, required none", m_data);
         end else begin
            mon_exp = exp_q.pop_front();
            check_output("word", 128'({m_last, m_data}), 128'(mon_exp));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0]   ctrl_req;
      logic [127:0] blk;
      int           base_pops;
      int           emitted;

      total = 0; bad = 0; pop_count = 0; word_count = 0;
      ct_valid = 1'b0;
      ct_data  = '0;
      m_ready  = 1'b1;
      rst      = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b1;
      tick();

      // Single block: pop at t+2, words t+4..t+7, m_last only on the final word.
      apply_stimulus(V1);
      for (int k = 0; k < 8; k++) begin
         tick();
         ct_valid = 1'b0;
         ctrl_req = {(k == 1), (k >= 3 && k <= 6), (k == 6)};
         check_output($sformatf("t1_ctrl_k%0d", k), 128'({fifo_rd_en_t, m_valid, m_last}), 128'(ctrl_req));
         if (k == 0) check_output("t1_credits_t1", 128'(credits), 128'(1));
         if (k == 3) check_output("t1_first_word", 128'(m_data), 128'(32'h00112233));
         if (k == 6) check_output("t1_last_word", 128'(m_data), 128'(32'hCCDDEEFF));
      end
      check_output("t1_blk_cnt", 128'(blk_cnt), 128'(1));
      check_output("t1_credits", 128'(credits), 128'(0));

      // Back-pressure on word 1 for five cycles.
      apply_stimulus(V1);
      tick();
      ct_valid = 1'b0;
      repeat (4) tick();
      m_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         check_output("t2_stall_valid", 128'(m_valid), 128'(1));
         check_output("t2_stall_data",  128'(m_data),  128'(32'h44556677));
         check_output("t2_stall_last",  128'(m_last),  128'(0));
         tick();
      end
      m_ready = 1'b1;
      wait_blocks(2, 20);
      check_output("t2_words", 128'(word_count), 128'(8));

      // Burst of three; the third pulse lands on the POP cycle.
      base_pops = pop_count;
      apply_stimulus(128'h10000001_10000002_10000003_10000004);
      tick();
      check_output("t3_credits_a", 128'(credits), 128'(1));
      apply_stimulus(128'h20000001_20000002_20000003_20000004);
      tick();
      check_output("t3_credits_b", 128'(credits), 128'(2));
      check_output("t3_pop_now",   128'(fifo_rd_en_t), 128'(1));
      apply_stimulus(128'h30000001_30000002_30000003_30000004);
      tick();
      ct_valid = 1'b0;
      check_output("t3_credits_c", 128'(credits), 128'(2));
      wait_blocks(5, 60);
      check_output("t3_credits_end", 128'(credits), 128'(0));
      check_output("t3_pops", 128'(pop_count - base_pops), 128'(3));
      check_output("t3_words", 128'(word_count), 128'(20));

      // Overflow: one block stalled in SEND, then eighteen pulses.
      apply_stimulus(128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3);
      tick();
      ct_valid = 1'b0;
      for (int n = 0; n < 10 && !m_valid; n++) tick();
      m_ready = 1'b0;
      check_output("t4_stalled_valid", 128'(m_valid), 128'(1));
      for (int i = 0; i < 18; i++) begin
         blk = {16'hC000 | 16'(i), 16'h0011, 16'hC000 | 16'(i), 16'h0022,
                16'hC000 | 16'(i), 16'h0033, 16'hC000 | 16'(i), 16'h0044};
         apply_stimulus(blk);
         tick();
         check_output($sformatf("t4_credits_%0d", i), 128'(credits), 128'((i + 1 < 16) ? i + 1 : 16));
         check_output($sformatf("t4_overflow_%0d", i), 128'(overflow), 128'(i >= 16));
      end
      ct_valid = 1'b0;
      tick();
      check_output("t4_hold_data", 128'(m_data), 128'(32'hD0D0D0D0));
      m_ready = 1'b1;
      wait_blocks(22, 200);
      check_output("t4_credits_end", 128'(credits), 128'(0));
      check_output("t4_overflow_sticky", 128'(overflow), 128'(1));
      check_output("t4_words", 128'(word_count), 128'(88));
      check_output("t4_exp_empty", 128'(exp_q.size()), 128'(0));

      // Reset during word 2 drops the block and clears everything asynchronously.
      apply_stimulus(128'hE0000000_E1111111_E2222222_E3333333);
      tick();
      ct_valid = 1'b0;
      repeat (5) tick();
      check_output("t5_word2", 128'(m_data), 128'(32'hE2222222));
      #2 rst = 1'b0;
      #1 check_reset_values("t5_async");
      fifo_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      emitted = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (m_valid || fifo_rd_en_t) emitted++;
      end
      check_output("t5_no_emit", 128'(emitted), 128'(0));
      check_output("t5_overflow_clr", 128'(overflow), 128'(0));
      apply_stimulus(128'hF0F0F0F0_F1F1F1F1_F2F2F2F2_F3F3F3F3);
      tick();
      ct_valid = 1'b0;
      wait_blocks(1, 20);
      check_output("t5_exp_empty", 128'(exp_q.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
